// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory bus: upstream offer (adder outputs plus control bits),
// downstream registered entry, and the architectural NZCV flags.
//
// Handshake rule, on both sides: a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised, the payload
// must stay stable until that transfer. ready may depend on the state of the
// receiving side, but never on valid.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
);
    // Upstream offer from the execute stage
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              NegativeFlag;
    logic              ZeroFlag;
    logic              op_a_msb;
    logic              op_b_msb;
    logic [DATA_W-1:0] store_data;
    logic [3:0]        cond;
    logic              set_flags;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic [RD_W-1:0]   rd;
    logic              flush;

    // Downstream registered entry
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data_q;
    logic              reg_write_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;
    logic [RD_W-1:0]   rd_q;
    logic              cond_pass_q;
    logic [3:0]        flags;

    // Side that drives the offer and consumes the entry
    modport master (
        output in_valid, sum, cout, NegativeFlag, ZeroFlag, op_a_msb, op_b_msb,
               store_data, cond, set_flags, reg_write, mem_write, mem_to_reg,
               rd, flush, out_ready,
        input  in_ready, out_valid, alu_result, store_data_q, reg_write_q,
               mem_write_q, mem_to_reg_q, rd_q, cond_pass_q, flags
    );

    // The pipeline stage itself
    modport slave (
        input  in_valid, sum, cout, NegativeFlag, ZeroFlag, op_a_msb, op_b_msb,
               store_data, cond, set_flags, reg_write, mem_write, mem_to_reg,
               rd, flush, out_ready,
        output in_ready, out_valid, alu_result, store_data_q, reg_write_q,
               mem_write_q, mem_to_reg_q, rd_q, cond_pass_q, flags
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the adder result and control bits,
// holds the NZCV flag register, and squashes register/memory writes of
// instructions whose condition code fails against the current flags.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);

    logic              valid_q, valid_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic              regw_q, regw_d;
    logic              memw_q, memw_d;
    logic              m2r_q, m2r_d;
    logic [RD_W-1:0]   rd_reg_q, rd_reg_d;
    logic              pass_q, pass_d;

    logic              in_ready;
    logic              accept;
    logic              drain;
    logic              cond_pass;
    logic              ovf;

    // Flag bits of the current register, before any update this cycle
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // A slot frees up when it is empty or being drained this very cycle
    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;
    assign drain    = valid_q && bus.out_ready;

    // Signed overflow: operands share a sign that the result does not
    assign ovf = (bus.op_a_msb == bus.op_b_msb) && (bus.sum[DATA_W-1] != bus.op_a_msb);

    // Condition code evaluated against the flags register as it stands now
    always_comb begin
        cond_pass = 1'b0;
        case (bus.cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Next state: flush wins, then accept (which may overlap a drain), then drain
    always_comb begin
        valid_d  = valid_q;
        flags_d  = flags_q;
        alu_d    = alu_q;
        sdata_d  = sdata_q;
        regw_d   = regw_q;
        memw_d   = memw_q;
        m2r_d    = m2r_q;
        rd_reg_d = rd_reg_q;
        pass_d   = pass_q;
        if (bus.flush) begin
            // Data registers are left stale; only the valid bit matters
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            alu_d    = bus.sum;
            sdata_d  = bus.store_data;
            regw_d   = bus.reg_write && cond_pass;
            memw_d   = bus.mem_write && cond_pass;
            m2r_d    = bus.mem_to_reg;
            rd_reg_d = bus.rd;
            pass_d   = cond_pass;
            // Flags move at acceptance so the next offer already sees them
            if (bus.set_flags && cond_pass) begin
                flags_d = {bus.NegativeFlag, bus.ZeroFlag, bus.cout, ovf};
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            flags_q  <= 4'b0000;
            alu_q    <= '0;
            sdata_q  <= '0;
            regw_q   <= 1'b0;
            memw_q   <= 1'b0;
            m2r_q    <= 1'b0;
            rd_reg_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            flags_q  <= flags_d;
            alu_q    <= alu_d;
            sdata_q  <= sdata_d;
            regw_q   <= regw_d;
            memw_q   <= memw_d;
            m2r_q    <= m2r_d;
            rd_reg_q <= rd_reg_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.flags        = flags_q;
    assign bus.alu_result   = alu_q;
    assign bus.store_data_q = sdata_q;
    assign bus.reg_write_q  = regw_q;
    assign bus.mem_write_q  = memw_q;
    assign bus.mem_to_reg_q = m2r_q;
    assign bus.rd_q         = rd_reg_q;
    assign bus.cond_pass_q  = pass_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed offers, a reference model of the stage
// updated on every clock, a compare process on the falling edge, and
// hand-computed literal expectations at key points.
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;

  logic clk;
  logic reset;

  ex_mem_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  ex_mem_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic              regw;
    logic              memw;
    logic              m2r;
    logic [RD_W-1:0]   rd;
    logic              pass;
  } entry_t;

  logic   m_valid;
  logic [3:0] m_flags;
  entry_t m_entry;

  // Condition table in terms of named flags
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic take, p, v_bit;
    if (reset) begin
      m_valid = 1'b0;
      m_flags = 4'b0000;
      m_entry = '0;
    end else begin
      take = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
      if (bus.flush) begin
        m_valid = 1'b0;
      end else if (take) begin
        p = cond_true(bus.cond, m_flags);
        m_entry.alu   = bus.sum;
        m_entry.sdata = bus.store_data;
        m_entry.regw  = bus.reg_write & p;
        m_entry.memw  = bus.mem_write & p;
        m_entry.m2r   = bus.mem_to_reg;
        m_entry.rd    = bus.rd;
        m_entry.pass  = p;
        m_valid       = 1'b1;
        v_bit = (bus.op_a_msb == bus.op_b_msb) && (bus.sum[DATA_W-1] != bus.op_a_msb);
        if (bus.set_flags && p) m_flags = {bus.NegativeFlag, bus.ZeroFlag, bus.cout, v_bit};
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      chk("flags", 32'(bus.flags), 32'(m_flags));
      if (m_valid) begin
        chk("alu_result", bus.alu_result, m_entry.alu);
        chk("store_data_q", bus.store_data_q, m_entry.sdata);
        chk("reg_write_q", 32'(bus.reg_write_q), 32'(m_entry.regw));
        chk("mem_write_q", 32'(bus.mem_write_q), 32'(m_entry.memw));
        chk("mem_to_reg_q", 32'(bus.mem_to_reg_q), 32'(m_entry.m2r));
        chk("rd_q", 32'(bus.rd_q), 32'(m_entry.rd));
        chk("cond_pass_q", 32'(bus.cond_pass_q), 32'(m_entry.pass));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] s, input logic co, input logic n, input logic z,
                       input logic am, input logic bm, input logic [3:0] c, input logic sf,
                       input logic rw, input logic mw, input logic [3:0] r);
    bus.in_valid     = 1'b1;
    bus.sum          = s;
    bus.cout         = co;
    bus.NegativeFlag = n;
    bus.ZeroFlag     = z;
    bus.op_a_msb     = am;
    bus.op_b_msb     = bm;
    bus.store_data   = s ^ 32'hFFFF_0000;
    bus.cond         = c;
    bus.set_flags    = sf;
    bus.reg_write    = rw;
    bus.mem_write    = mw;
    bus.mem_to_reg   = c[0];
    bus.rd           = r;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.set_flags = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    offer(32'h0, 0, 0, 0, 0, 0, 4'hE, 0, 0, 0, 4'h0);
    idle();
    cycle();
    cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_alu", bus.alu_result, 32'd0);
    reset = 1'b0;
    cycle();

    // ADDS of two negatives giving 0 with carry: operands share sign 1, result
    // sign 0, so the overflow rule sets V as well -> NZCV = 0111
    offer(32'h0, 1, 0, 1, 1, 1, 4'hE, 1, 1, 0, 4'h3);
    cycle();
    chk("adds_valid", 32'(bus.out_valid), 32'd1);
    chk("adds_alu", bus.alu_result, 32'd0);
    chk("adds_flags", 32'(bus.flags), 32'b0111);

    // Positive + positive wrapping to negative: N and V
    offer(32'h8000_0000, 0, 1, 0, 0, 0, 4'hE, 1, 1, 0, 4'h4);
    cycle();
    chk("ovf_flags", 32'(bus.flags), 32'b1001);

    // GE with N==V passes
    offer(32'h5, 0, 0, 0, 0, 0, 4'hA, 0, 1, 0, 4'h5);
    cycle();
    chk("ge_pass", 32'(bus.cond_pass_q), 32'd1);
    chk("ge_regw", 32'(bus.reg_write_q), 32'd1);

    // EQ with Z=0 fails: writes squashed, flags untouched
    offer(32'h77, 1, 0, 1, 0, 0, 4'h0, 1, 1, 1, 4'h6);
    cycle();
    chk("eq_valid", 32'(bus.out_valid), 32'd1);
    chk("eq_pass", 32'(bus.cond_pass_q), 32'd0);
    chk("eq_regw", 32'(bus.reg_write_q), 32'd0);
    chk("eq_memw", 32'(bus.mem_write_q), 32'd0);
    chk("eq_flags", 32'(bus.flags), 32'b1001);

    // Never-code behaves the same
    offer(32'hDEAD_0001, 1, 0, 1, 0, 0, 4'hF, 1, 1, 1, 4'h7);
    cycle();
    chk("nv_pass", 32'(bus.cond_pass_q), 32'd0);
    chk("nv_memw", 32'(bus.mem_write_q), 32'd0);
    chk("nv_flags", 32'(bus.flags), 32'b1001);

    // Backpressure: entry and flags frozen, offer refused
    bus.out_ready = 1'b0;
    offer(32'h1234, 1, 0, 0, 0, 1, 4'hE, 1, 1, 0, 4'h8);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_alu", bus.alu_result, 32'hDEAD_0001);
      chk("bp_flags", 32'(bus.flags), 32'b1001);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("rel_valid", 32'(bus.out_valid), 32'd1);
    chk("rel_alu", bus.alu_result, 32'h1234);
    chk("rel_flags", 32'(bus.flags), 32'b0010);

    // Flush beats a flag-setting offer
    offer(32'hFFFF, 1, 1, 1, 1, 1, 4'hE, 1, 1, 1, 4'h9);
    bus.flush = 1'b1;
    cycle();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_flags", 32'(bus.flags), 32'b0010);
    bus.flush = 1'b0;
    idle();
    cycle();
    chk("fl_after_valid", 32'(bus.out_valid), 32'd0);

    // Drain without a new offer empties the stage
    offer(32'hA5, 0, 0, 0, 0, 0, 4'hE, 0, 1, 0, 4'h1);
    cycle();
    idle();
    cycle();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Flags 0010: HI passes, LS fails
    offer(32'h11, 0, 0, 0, 0, 0, 4'h8, 0, 1, 0, 4'h2);
    cycle();
    chk("hi_pass", 32'(bus.cond_pass_q), 32'd1);
    offer(32'h12, 0, 0, 0, 0, 0, 4'h9, 0, 1, 0, 4'h2);
    cycle();
    chk("ls_pass", 32'(bus.cond_pass_q), 32'd0);

    // Sweep every code under three flag patterns
    for (int pat = 0; pat < 3; pat++) begin
      if (pat == 1) offer(32'h0000_0010, 0, 1, 1, 0, 0, 4'hE, 1, 0, 0, 4'h0); // -> 1100
      if (pat == 2) offer(32'h8000_0000, 0, 0, 0, 0, 0, 4'hE, 1, 0, 0, 4'h0); // -> 0001
      if (pat != 0) cycle();
      for (int c = 0; c < 16; c++) begin
        offer(32'(c * 3 + pat), 0, 0, 0, 0, 0, 4'(c), 0, 1, 1, 4'(c));
        cycle();
      end
    end
    chk("sweep_flags", 32'(bus.flags), 32'b0001);

    // Reset while holding an entry with every flag set
    offer(32'h8000_0000, 1, 1, 1, 0, 0, 4'hE, 1, 1, 1, 4'hA);
    cycle();
    chk("pre_rst_flags", 32'(bus.flags), 32'b1111);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    idle();
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_flags", 32'(bus.flags), 32'd0);
    chk("arst_alu", bus.alu_result, 32'd0);
    chk("arst_sdata", bus.store_data_q, 32'd0);
    chk("arst_rd", 32'(bus.rd_q), 32'd0);
    chk("arst_ctrl", {28'd0, bus.reg_write_q, bus.mem_write_q, bus.mem_to_reg_q, bus.cond_pass_q}, 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
